// File: rtl/aes_decrypt_sequencer.sv
// Control sequencer for the AES-128 inverse-cipher datapath: turns the START level
// into the key-expansion / load / inverse-round schedule and reports DONE.
module aes_decrypt_sequencer #(
  parameter int unsigned KEYEXP_CYCLES = 10,
  parameter int unsigned NUM_ROUNDS    = 10
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       AES_START,
  output logic       AES_DONE,
  output logic       BUSY,
  output logic       KEYEXP_EN,
  output logic       STATE_LD,
  output logic [2:0] OP_SEL,
  output logic [3:0] ROUND_IDX,
  output logic [1:0] COL_IDX
);

  localparam logic [7:0] KEYEXP_LAST = 8'(KEYEXP_CYCLES - 1);
  localparam logic [3:0] ROUND_INIT  = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] ROUND_TOP   = 4'(NUM_ROUNDS);

  typedef enum logic [3:0] {
    IDLE, KEY_EXP, LOAD, ARK_INIT, ISR, ISB, ARK, IMC, DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE, OP_LOAD_MSG, OP_ADD_ROUND_KEY, OP_INV_SHIFT_ROWS,
    OP_INV_SUB_BYTES, OP_INV_MIX_COL
  } op_t;

  state_t     state, state_n;
  logic [3:0] round, round_n;
  logic [1:0] col, col_n;
  logic [7:0] kcnt, kcnt_n;
  op_t        op;
  logic       busy;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      round <= ROUND_INIT;
      col   <= '0;
      kcnt  <= '0;
    end else begin
      state <= state_n;
      round <= round_n;
      col   <= col_n;
      kcnt  <= kcnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    round_n   = round;
    col_n     = col;
    kcnt_n    = kcnt;
    op        = OP_NONE;
    AES_DONE  = 1'b0;
    KEYEXP_EN = 1'b0;
    STATE_LD  = 1'b0;
    ROUND_IDX = '0;
    COL_IDX   = '0;
    busy      = (state != IDLE) && (state != DONE);

    case (state)
      IDLE: begin
        if (AES_START) begin
          state_n = KEY_EXP;
          kcnt_n  = '0;
        end
      end
      KEY_EXP: begin
        KEYEXP_EN = 1'b1;
        if (kcnt == KEYEXP_LAST) state_n = LOAD;
        else                     kcnt_n  = kcnt + 8'd1;
      end
      LOAD: begin
        op       = OP_LOAD_MSG;
        STATE_LD = 1'b1;
        state_n  = ARK_INIT;
      end
      ARK_INIT: begin
        op        = OP_ADD_ROUND_KEY;
        ROUND_IDX = ROUND_TOP;
        STATE_LD  = 1'b1;
        round_n   = ROUND_INIT;
        state_n   = ISR;
      end
      ISR: begin
        op       = OP_INV_SHIFT_ROWS;
        STATE_LD = 1'b1;
        state_n  = ISB;
      end
      ISB: begin
        op       = OP_INV_SUB_BYTES;
        STATE_LD = 1'b1;
        state_n  = ARK;
      end
      ARK: begin
        op        = OP_ADD_ROUND_KEY;
        ROUND_IDX = round;
        STATE_LD  = 1'b1;
        if (round != '0) begin
          state_n = IMC;
          col_n   = '0;
        end else begin
          state_n = DONE;
        end
      end
      IMC: begin
        // One column per cycle through the shared InvMixColumns unit.
        op       = OP_INV_MIX_COL;
        COL_IDX  = col;
        STATE_LD = 1'b1;
        if (col == 2'd3) begin
          round_n = round - 4'd1;
          col_n   = '0;
          state_n = ISR;
        end else begin
          col_n = col + 2'd1;
        end
      end
      DONE: begin
        AES_DONE = 1'b1;
        if (!AES_START) begin
          state_n = IDLE;
          round_n = ROUND_INIT;
          col_n   = '0;
          kcnt_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    // Dropping START mid-schedule abandons the run and restores reset counters.
    if (busy && !AES_START) begin
      state_n = IDLE;
      round_n = ROUND_INIT;
      col_n   = '0;
      kcnt_n  = '0;
    end
  end

  assign BUSY   = busy;
  assign OP_SEL = op;

endmodule
